// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// master drives operands and out_ready; slave is the arithmetic unit.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op_a, op_b, sub, c_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, c_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLK_W-bit lookahead block resolved per stage,
// carry and partial sum skewed through registers, global-stall valid/ready handshake.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK_W = 8
) (
    input logic                   clock,
    input logic                   reset,
    pipelined_cla_addsub_if.slave bus
);
    localparam int NUM_BLK = WIDTH / BLK_W;

    // Carry into bit i is the group generate/propagate of bits below i, not a ripple chain.
    function automatic logic [BLK_W:0] cla_blk(input logic [BLK_W-1:0] a,
                                               input logic [BLK_W-1:0] b,
                                               input logic             cin);
        logic [BLK_W-1:0] g;
        logic [BLK_W-1:0] p;
        logic [BLK_W-1:0] s;
        logic             grp_g;
        logic             grp_p;
        g     = a & b;
        p     = a ^ b;
        s     = '0;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < BLK_W; i++) begin
            s[i]  = p[i] ^ (grp_g | (grp_p & cin));
            grp_g = g[i] | (p[i] & grp_g);
            grp_p = grp_p & p[i];
        end
        return {grp_g | (grp_p & cin), s};
    endfunction

    // Slot k holds operands (B already inverted for subtract) waiting for block k.
    logic             v_q [NUM_BLK];
    logic [WIDTH-1:0] a_q [NUM_BLK];
    logic [WIDTH-1:0] b_q [NUM_BLK];
    logic [WIDTH-1:0] s_q [NUM_BLK];
    logic             c_q [NUM_BLK];

    logic [WIDTH-1:0] s_nxt [NUM_BLK];
    logic             c_nxt [NUM_BLK];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;
    logic             advance;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

    always_comb begin
        for (int k = 0; k < NUM_BLK; k++) begin
            s_nxt[k] = s_q[k];
            c_nxt[k] = 1'b0;
            {c_nxt[k], s_nxt[k][k*BLK_W +: BLK_W]} =
                cla_blk(a_q[k][k*BLK_W +: BLK_W], b_q[k][k*BLK_W +: BLK_W], c_q[k]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BLK; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            v_q[0] <= bus.in_valid;
            a_q[0] <= bus.op_a;
            b_q[0] <= bus.sub ? ~bus.op_b : bus.op_b;
            s_q[0] <= '0;
            c_q[0] <= bus.sub ? 1'b1 : bus.c_in;
            for (int k = 1; k < NUM_BLK; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_nxt[k-1];
                c_q[k] <= c_nxt[k-1];
            end
            out_valid_q <= v_q[NUM_BLK-1];
            // Result fields only move on a real result so they hold across bubbles.
            if (v_q[NUM_BLK-1]) begin
                sum_q       <= s_nxt[NUM_BLK-1];
                carry_out_q <= c_nxt[NUM_BLK-1];
                overflow_q  <= (a_q[NUM_BLK-1][WIDTH-1] == b_q[NUM_BLK-1][WIDTH-1]) &&
                               (s_nxt[NUM_BLK-1][WIDTH-1] != a_q[NUM_BLK-1][WIDTH-1]);
                zero_q      <= (s_nxt[NUM_BLK-1] == '0);
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH=32, BLK_W=8) with hand-computed vectors.
module tb_pipelined_cla_addsub;
    localparam int LAT = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
        int          st;
        bit          seen;
    } exp_t;

    logic clock;
    logic reset;

    pipelined_cla_addsub_if #(.WIDTH(32)) bus ();

    pipelined_cla_addsub #(.WIDTH(32), .BLK_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    vec_t vecs [14];
    vec_t cur;
    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   st       = 0;
    int   n_rx     = 0;
    int   n_unexp  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Input side: record expected result whenever an operand set is taken.
    always @(negedge clock) begin
        if (!reset && bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.s = cur.s; e.c = cur.c; e.o = cur.o; e.z = cur.z;
            e.acc = cyc + 1; e.st = st; e.seen = 1'b0;
            sb.push_back(e);
        end
    end

    // Output side: compare every presented result; pop on handshake.
    always @(negedge clock) begin
        if (!reset) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_unexp++;
                    $display("FAIL unexpected_result: got sum %h with no result outstanding (cycle %0d)",
                             bus.sum, cyc);
                end else begin
                    if (!sb[0].seen) begin
                        chk("latency", 32'(cyc), 32'(sb[0].acc + LAT + (st - sb[0].st)));
                        sb[0].seen = 1'b1;
                    end
                    chk("sum", bus.sum, sb[0].s);
                    chk("carry_out", 32'(bus.carry_out), 32'(sb[0].c));
                    chk("overflow", 32'(bus.overflow), 32'(sb[0].o));
                    chk("zero", 32'(bus.zero), 32'(sb[0].z));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        n_rx++;
                    end
                end
                if (!bus.out_ready) st++;
            end
        end
    end

    task automatic send(input vec_t v);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        cur          = v;
        bus.in_valid = 1'b1;
        bus.op_a     = v.a;
        bus.op_b     = v.b;
        bus.sub      = v.sub;
        bus.c_in     = v.cin;
        while (!ok && n < 50) begin
            @(negedge clock);
            n++;
            if (bus.in_ready) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: operand not taken after %0d cycles", n);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0001, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b1;
        cur           = vecs[0];
        idle(3);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_sum", bus.sum, 32'd0);
        chk("rst_flags", {29'd0, bus.carry_out, bus.overflow, bus.zero}, 32'd0);
        reset = 1'b0;
        idle(1);

        // Isolated directed operations.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i]);
            idle(6);
        end

        // Eight back-to-back operations, consumer always ready.
        for (int i = 4; i < 12; i++) send(vecs[i]);
        idle(8);

        // Stream with a 3-cycle consumer stall in the middle.
        fork
            begin
                send(vecs[12]);
                send(vecs[13]);
                for (int i = 4; i < 10; i++) send(vecs[i]);
            end
            begin
                idle(6);
                bus.out_ready = 1'b0;
                idle(3);
                bus.out_ready = 1'b1;
            end
        join
        idle(10);

        // Reset with results in flight: nothing stale may emerge afterwards.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[i]);
        begin
            int  n;
            bit  got;
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clock);
                n++;
                if (bus.out_valid) got = 1'b1;
            end
            if (!got) begin
                n_checks++;
                $display("FAIL wait_out_valid: out_valid not seen within %0d cycles", n);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", bus.sum, 32'd0);
        chk("midrst_flags", {29'd0, bus.carry_out, bus.overflow, bus.zero}, 32'd0);
        sb.delete();
        idle(2);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        idle(12);

        chk("no_stale_results", 32'(n_unexp), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("results_received", 32'(n_rx), 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
